// File: rtl/generic_rr_arb.sv
// generic_rr_arb: registered round-robin / fixed-priority arbiter with data mux.
// The winner's data, one-hot grant and binary index are captured into a
// single output register behind a valid/ready handshake.
// Optional multi-beat lock: define GENERIC_RR_ARB_LOCK_EN.

// Per-requester qualification: eligibility under the lock and whether the
// requester sits at or above the round-robin pointer.
module generic_rr_arb_lane #(
    parameter int IDX  = 0,
    parameter int SIZE = 1
) (
    input  logic            req,
    input  logic            lock_ok,
    input  logic [SIZE-1:0] ptr,
    output logic            elig,
    output logic            upper
);
    localparam logic [SIZE-1:0] IDX_S = SIZE'(IDX);

    // Upper-half membership drives the wrap-around scan.
    assign elig  = req & lock_ok;
    assign upper = elig && (IDX_S >= ptr);
endmodule

module generic_rr_arb #(
    parameter int WIDTH      = 8,
    parameter int DATA_WIDTH = 4,
    parameter int SIZE       = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1,
    parameter int MODE_RR    = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [WIDTH-1:0]                 req_in,
    input  logic [WIDTH-1:0]                 last_in,
    input  logic [WIDTH-1:0][DATA_WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]                 req_ack,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [WIDTH-1:0]                 out_grant,
    output logic [SIZE-1:0]                  out_enc
);
    logic [SIZE-1:0]  ptr;
    logic [WIDTH-1:0] lock_mask;
    logic [WIDTH-1:0] elig;
    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] pick;
    logic [WIDTH-1:0] onehot;
    logic [SIZE-1:0]  win;
    logic             load;
    logic             ptr_adv;

`ifdef GENERIC_RR_ARB_LOCK_EN
    logic             locked;
    logic [SIZE-1:0]  lock_idx;

    // While locked only the lock holder may be arbitrated.
    always_comb begin
        lock_mask = '1;
        if (locked) lock_mask = WIDTH'(1) << lock_idx;
    end

    // Pointer is frozen for continuation beats of a locked transfer.
    assign ptr_adv = !locked || last_in[win];

    // Lock taken on a non-final beat, released on the final beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked   <= 1'b0;
            lock_idx <= '0;
        end else if (load) begin
            if (!last_in[win]) begin
                locked   <= 1'b1;
                lock_idx <= win;
            end else begin
                locked   <= 1'b0;
            end
        end
    end
`else
    logic unused_last;

    assign lock_mask   = '1;
    assign ptr_adv     = 1'b1;
    assign unused_last = ^last_in;
`endif

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        generic_rr_arb_lane #(.IDX(g), .SIZE(SIZE)) u_lane (
            .req     (req_in[g]),
            .lock_ok (lock_mask[g]),
            .ptr     (ptr),
            .elig    (elig[g]),
            .upper   (upper[g])
        );
    end

    // Winner: lowest eligible at/above ptr, else wrap to lowest eligible overall.
    always_comb begin
        pick = (|upper) ? upper : elig;
        win  = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pick[i]) win = SIZE'(i);
        end
    end

    assign onehot  = WIDTH'(1) << win;
    assign load    = (|elig) && (!out_valid || out_ready);
    assign req_ack = load ? onehot : '0;

    // Round-robin pointer: one past the winner, modulo WIDTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if ((MODE_RR != 0) && load && ptr_adv) begin
            ptr <= (win == SIZE'(WIDTH - 1)) ? '0 : win + 1'b1;
        end
    end

    // Output slice: load replaces the beat, otherwise ready retires it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_grant <= '0;
            out_enc   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= data_in[win];
            out_grant <= onehot;
            out_enc   <= win;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_generic_rr_arb.sv
// Bench for generic_rr_arb: round-robin WIDTH=8 and WIDTH=5, fixed priority,
// and (when GENERIC_RR_ARB_LOCK_EN is defined) the multi-beat lock.
module tb_generic_rr_arb;
    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] enc;
        logic [3:0] data;
    } exp_t;

    typedef struct packed {
        logic [7:0] req;
        logic       rdy;
        logic [7:0] ack;
        logic       valid;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // WIDTH=8 round-robin
    logic [7:0]      req8, last8, ack8, grant8;
    logic [7:0][3:0] data8;
    logic            rdy8, val8;
    logic [3:0]      dout8;
    logic [2:0]      enc8;
    // WIDTH=5 round-robin
    logic [4:0]      req5, last5, ack5, grant5;
    logic [4:0][3:0] data5;
    logic            rdy5, val5;
    logic [3:0]      dout5;
    logic [2:0]      enc5;
    // WIDTH=8 fixed priority
    logic [7:0]      reqf, lastf, ackf, grantf;
    logic [7:0][3:0] dataf;
    logic            rdyf, valf;
    logic [3:0]      doutf;
    logic [2:0]      encf;

    generic_rr_arb #(.WIDTH(8), .DATA_WIDTH(4), .MODE_RR(1)) u8 (
        .clk(clk), .reset_n(reset_n), .req_in(req8), .last_in(last8), .data_in(data8),
        .req_ack(ack8), .out_valid(val8), .out_ready(rdy8), .out_data(dout8),
        .out_grant(grant8), .out_enc(enc8));

    generic_rr_arb #(.WIDTH(5), .DATA_WIDTH(4), .MODE_RR(1)) u5 (
        .clk(clk), .reset_n(reset_n), .req_in(req5), .last_in(last5), .data_in(data5),
        .req_ack(ack5), .out_valid(val5), .out_ready(rdy5), .out_data(dout5),
        .out_grant(grant5), .out_enc(enc5));

    generic_rr_arb #(.WIDTH(8), .DATA_WIDTH(4), .MODE_RR(0)) uf (
        .clk(clk), .reset_n(reset_n), .req_in(reqf), .last_in(lastf), .data_in(dataf),
        .req_ack(ackf), .out_valid(valf), .out_ready(rdyf), .out_data(doutf),
        .out_grant(grantf), .out_enc(encf));

    exp_t sb[$];
    exp_t last_exp;
    vec_t vec[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reset pulse; outputs are checked while reset is held.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req8 = '0; req5 = '0; reqf = '0;
        #1;
        chk("rst_valid", 32'(val8), 32'd0);
        chk("rst_grant", 32'(grant8), 32'd0);
        chk("rst_enc",   32'(enc8), 32'd0);
        chk("rst_data",  32'(dout8), 32'd0);
        chk("rst_ack",   32'(ack8), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        last_exp = '0;
        sb.delete();
    endtask

    // One cycle on the WIDTH=8 RR instance with scoreboarded output check.
    task automatic step8(input logic [7:0] r, input logic rd, input logic [7:0] l,
                         input logic [7:0] ea, input logic ev);
        exp_t e;
        @(negedge clk);
        req8 = r; rdy8 = rd; last8 = l; cyc++;
        for (int i = 0; i < 8; i++) data8[i] = 4'(i * 5 + cyc);
        #1;
        chk("req_ack", 32'(ack8), 32'(ea));
        if (ea != 8'd0) begin
            e.grant = ea;
            e.enc   = '0;
            for (int i = 0; i < 8; i++) if (ea[i]) e.enc = 3'(i);
            e.data  = data8[e.enc];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(val8), 32'(ev));
        if (ea != 8'd0 && sb.size() > 0) last_exp = sb.pop_front();
        chk("out_grant", 32'(grant8), 32'(last_exp.grant));
        chk("out_enc",   32'(enc8),   32'(last_exp.enc));
        chk("out_data",  32'(dout8),  32'(last_exp.data));
    endtask

    initial begin
        logic [3:0] expd;
        reset_n = 1'b0;
        req8 = '0; last8 = '1; rdy8 = 1'b1; data8 = '0;
        req5 = '0; last5 = '1; rdy5 = 1'b1; data5 = '0;
        reqf = '0; lastf = '1; rdyf = 1'b1; dataf = '0;
        last_exp = '0;

        // {req, ready, expected ack, expected out_valid after the edge}
        for (int k = 0; k < 5; k++) vec.push_back('{8'h00, 1'b1, 8'h00, 1'b0});
        for (int k = 0; k < 9; k++) vec.push_back('{8'hFF, 1'b1, 8'(1 << (k % 8)), 1'b1});
        vec.push_back('{8'h00, 1'b1, 8'h00, 1'b0});
        vec.push_back('{8'h0C, 1'b0, 8'h04, 1'b1});
        vec.push_back('{8'h0C, 1'b0, 8'h00, 1'b1});
        vec.push_back('{8'h0C, 1'b0, 8'h00, 1'b1});
        vec.push_back('{8'h0C, 1'b1, 8'h08, 1'b1});
        vec.push_back('{8'h0C, 1'b1, 8'h04, 1'b1});
        vec.push_back('{8'h00, 1'b0, 8'h00, 1'b1});
        vec.push_back('{8'h00, 1'b1, 8'h00, 1'b0});
        vec.push_back('{8'h30, 1'b1, 8'h10, 1'b1});
        vec.push_back('{8'h30, 1'b1, 8'h20, 1'b1});
        vec.push_back('{8'h30, 1'b1, 8'h10, 1'b1});
        vec.push_back('{8'h00, 1'b1, 8'h00, 1'b0});

        do_reset();
        foreach (vec[k]) step8(vec[k].req, vec[k].rdy, 8'hFF, vec[k].ack, vec[k].valid);
        req8 = '0;

        // WIDTH=5 RR: 0 and 4 alternate, pointer wraps 4 -> 0
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req5 = 5'b10001; rdy5 = 1'b1; cyc++;
            for (int i = 0; i < 5; i++) data5[i] = 4'(i * 3 + cyc);
            #1;
            chk("w5_ack", 32'(ack5), (k % 2 == 0) ? 32'h01 : 32'h10);
            expd = data5[(k % 2 == 0) ? 0 : 4];
            @(posedge clk);
            #1;
            chk("w5_valid", 32'(val5), 32'd1);
            chk("w5_enc",   32'(enc5), (k % 2 == 0) ? 32'd0 : 32'd4);
            chk("w5_grant", 32'(grant5), (k % 2 == 0) ? 32'h01 : 32'h10);
            chk("w5_data",  32'(dout5), 32'(expd));
        end
        req5 = '0;

        // Fixed priority: index 2 always beats index 7
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            reqf = 8'h84; rdyf = 1'b1; cyc++;
            for (int i = 0; i < 8; i++) dataf[i] = 4'(i * 7 + cyc);
            #1;
            chk("fp_ack", 32'(ackf), 32'h04);
            expd = dataf[2];
            @(posedge clk);
            #1;
            chk("fp_valid", 32'(valf), 32'd1);
            chk("fp_enc",   32'(encf), 32'd2);
            chk("fp_grant", 32'(grantf), 32'h04);
            chk("fp_data",  32'(doutf), 32'(expd));
        end
        reqf = '0;

`ifdef GENERIC_RR_ARB_LOCK_EN
        // Source 3 locks for three beats while source 1 keeps requesting.
        do_reset();
        step8(8'h02, 1'b1, 8'hFF, 8'h02, 1'b1);   // moves ptr to 2
        step8(8'h0A, 1'b1, 8'hF7, 8'h08, 1'b1);   // beat 1, lock taken
        step8(8'h02, 1'b1, 8'hF7, 8'h00, 1'b0);   // source 1 shut out
        step8(8'h0A, 1'b1, 8'hF7, 8'h08, 1'b1);   // beat 2
        step8(8'h0A, 1'b1, 8'hFF, 8'h08, 1'b1);   // beat 3, lock released
        step8(8'h0A, 1'b1, 8'hFF, 8'h02, 1'b1);   // source 1 next

        // Reset after beat 2 drops the lock.
        do_reset();
        step8(8'h02, 1'b1, 8'hFF, 8'h02, 1'b1);
        step8(8'h0A, 1'b1, 8'hF7, 8'h08, 1'b1);
        step8(8'h0A, 1'b1, 8'hF7, 8'h08, 1'b1);
        do_reset();
        step8(8'h0A, 1'b1, 8'hF7, 8'h02, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/generic_rr_arb.md
# generic_rr_arb

Registered, parametrised arbiter with data multiplexing. It is the next generation of the combinational find-first-set encoder: selection is round-robin or fixed-priority, the winner's data is captured into an output register behind a valid/ready handshake, and an optional lock holds one requester across a multi-beat transfer. It sits wherever several trace/debug sources share one downstream channel, for example funnel inputs or MMR response merging.

## Interface
Parameters:
- `WIDTH`, default 8: number of requesters (≥1).
- `DATA_WIDTH`, default 4: data bits per requester.
- `SIZE`, default `max($clog2(WIDTH),1)`: encoded index width.
- `MODE_RR`, default 1: 1 = round-robin; 0 = fixed priority with the lowest index winning.

Ports:
- `clk`, input, 1: clock; all state on rising edge.
- `reset_n`, input, 1: asynchronous active-low reset.
- `req_in`, input, WIDTH: request per source.
- `last_in`, input, WIDTH: final-beat marker per source; ignored unless lock is compiled in.
- `data_in`, input, WIDTH×DATA_WIDTH: data per source.
- `req_ack`, output, WIDTH: one-hot, combinational; source i's beat is consumed this cycle.
- `out_valid`, output, 1: output register holds a beat.
- `out_ready`, input, 1: downstream accepts.
- `out_data`, output, DATA_WIDTH: registered winner data.
- `out_grant`, output, WIDTH: registered one-hot winner.
- `out_enc`, output, SIZE: registered binary winner index.

## Operation
- `load = (|req_in) && (!out_valid || out_ready)`.
- When `load` is high:
  - Winner w is selected.
  - `req_ack[w]=1`.
  - Next edge: `out_valid=1`, `out_data=data_in[w]`, `out_grant=1<<w`, `out_enc=w`.
- When `load` is low:
  - `req_ack=0`.
  - If `out_ready` is high, `out_valid` clears on the next edge. `out_data`, `out_grant` and `out_enc` hold their last values.
- Winner selection:
  - Round-robin: the first set `req_in` bit scanning upward from pointer `ptr`, wrapping from WIDTH-1 to 0.
  - Fixed priority: the lowest set bit; `ptr` is unused and stays 0.
- `ptr` (SIZE bits, reset 0) update on `load` in RR mode:
  - `ptr <= (w==WIDTH-1) ? 0 : w+1`.
  - Modulo WIDTH applies even when WIDTH is not a power of 2.
  - `ptr` never takes a value ≥ WIDTH.
- `WIDTH==1`: the block reduces to a single-entry register slice; `out_enc` is always 0.
- A requester must hold `req_in`/`data_in` stable until it sees `req_ack`. The arbiter never acks without a load.
- Simultaneous `out_ready` and a new request while full: the current beat retires and the new beat loads on the same edge (full throughput).

## Timing
- Request-to-`out_valid` latency: 1 cycle. Sustained throughput: 1 beat/cycle.
- `req_ack` is combinational from `req_in`, `out_valid`, `out_ready` and state. There is no combinational path from `data_in` to any output.
- Reset, asynchronous assert and synchronous-to-clock deassert:
  - `out_valid=0`, `out_data=0`, `out_grant=0`, `out_enc=0`.
  - `ptr=0`, lock state cleared.
- Reset mid-transfer drops the held beat and any active lock. There is no replay.

## Configuration
- `GENERIC_RR_ARB_LOCK_EN` defined:
  - A lock register (`locked`, `lock_idx`) is added.
  - A load of w with `last_in[w]=0` sets `locked=1`, `lock_idx=w`.
  - While locked:
    - Only `req_in[lock_idx]` is eligible. Other requests get no ack, even if the output is free.
    - `ptr` does not advance.
  - A load of `lock_idx` with `last_in=1` clears `locked` and sets `ptr` per the normal rule.
  - A lock taken in fixed-priority mode behaves identically.
- Macro undefined: no lock state exists. `last_in` is ignored and every beat is arbitrated independently.

## Test plan
- Reset, then `req_in=0` for 5 cycles:
  - `out_valid=0`, `req_ack=0`, all outputs 0.
- RR mode, WIDTH=8, `req_in=8'hFF` held, `out_ready=1`:
  - Grants 0,1,2,…,7,0 on consecutive cycles.
  - `out_enc` increments and wraps.
  - `out_data` matches source data each cycle.
- RR mode, WIDTH=5, `req_in=5'b10001`:
  - Grants alternate 0,4,0,4.
  - `ptr` wraps 4→0 and never reaches 5.
- Backpressure, `out_ready=0` for 3 cycles with `req_in=8'h0C`:
  - One beat (index 2) is loaded, then `req_ack=0` while stalled.
  - On `out_ready=1`, index 3 loads on the same edge index 2 retires.
- MODE_RR=0, `req_in=8'h84` held:
  - Index 2 wins every cycle; index 7 is never acked.
- `GENERIC_RR_ARB_LOCK_EN` defined, source 3 sends 3 beats with `last_in` asserted on beat 3, while source 1 requests continuously:
  - Grants are 3,3,3, then 1.
  - Asserting reset after beat 2 clears the lock, and source 1 is granted first after reset.
